// File: rtl/div_share_ctrl.sv
// Shares one iterative divider core between two requesters.
// A round-robin grant picks a requester, its operands are latched and the core
// is started with a single-cycle pulse. The result (or a divide-by-zero or
// watchdog-timeout answer) is held on the shared response port until it is
// consumed.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; READY is offered to the granted requester
// ISSUE | CORE_START high for this one cycle, watchdog counter cleared
// WAIT  | counting cycles until CORE_DONE or the watchdog limit
// RESP  | response held valid until RSP_READY

module div_share_ctrl #(
    parameter int DW      = 64,
    parameter int RW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          REQ0_VALID,
    output logic          REQ0_READY,
    input  logic [DW-1:0] REQ0_DVD,
    input  logic [DW-1:0] REQ0_DSR,

    input  logic          REQ1_VALID,
    output logic          REQ1_READY,
    input  logic [DW-1:0] REQ1_DVD,
    input  logic [DW-1:0] REQ1_DSR,

    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic          RSP_ID,
    output logic [RW-1:0] RSP_Q,
    output logic [RW-1:0] RSP_R,
    output logic [1:0]    RSP_ERR,

    output logic          CORE_START,
    output logic [DW-1:0] CORE_DVD,
    output logic [DW-1:0] CORE_DSR,
    input  logic          CORE_DONE,
    input  logic [RW-1:0] CORE_Q,
    input  logic [RW-1:0] CORE_R
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          rr_ptr;
    logic [CW-1:0] wait_cnt;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          grant_id;
    logic [DW-1:0] sel_dvd;
    logic [DW-1:0] sel_dsr;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        grant0 = REQ0_VALID && (!REQ1_VALID || !rr_ptr);
        grant1 = REQ1_VALID && (!REQ0_VALID ||  rr_ptr);
    end

    assign REQ0_READY = (state == IDLE) && grant0;
    assign REQ1_READY = (state == IDLE) && grant1;
    assign accept     = REQ0_READY || REQ1_READY;
    assign grant_id   = REQ1_READY;
    assign sel_dvd    = grant_id ? REQ1_DVD : REQ0_DVD;
    assign sel_dsr    = grant_id ? REQ1_DSR : REQ0_DSR;

    // Sequencer with all response and core-side outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            wait_cnt   <= '0;
            CORE_START <= 1'b0;
            CORE_DVD   <= '0;
            CORE_DSR   <= '0;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= 1'b0;
            RSP_Q      <= '0;
            RSP_R      <= '0;
            RSP_ERR    <= ERR_OK;
        end else begin
            CORE_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        CORE_DVD <= sel_dvd;
                        CORE_DSR <= sel_dsr;
                        RSP_ID   <= grant_id;
                        rr_ptr   <= ~grant_id;
                        if (sel_dsr == '0) begin
                            // Answered locally; the core is never started.
                            RSP_Q     <= '1;
                            RSP_R     <= sel_dvd[RW-1:0];
                            RSP_ERR   <= ERR_DIV0;
                            RSP_VALID <= 1'b1;
                            state     <= RESP;
                        end else begin
                            CORE_START <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    // DONE is checked first so it wins over a same-cycle timeout.
                    if (CORE_DONE) begin
                        RSP_Q     <= CORE_Q;
                        RSP_R     <= CORE_R;
                        RSP_ERR   <= ERR_OK;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        RSP_Q     <= '0;
                        RSP_R     <= '0;
                        RSP_ERR   <= ERR_TOUT;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // READY is only offered in IDLE, so no accept can overlap
                    // the handshake cycle.
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomized bench for div_share_ctrl with a transaction-level reference model
// and a behavioural divider core that answers after a chosen delay.

module tb_div_share_ctrl;

    localparam int DW      = 64;
    localparam int RW      = 32;
    localparam int TIMEOUT = 64;

    logic          CLK;
    logic          RST;
    logic          REQ0_VALID, REQ0_READY;
    logic [DW-1:0] REQ0_DVD, REQ0_DSR;
    logic          REQ1_VALID, REQ1_READY;
    logic [DW-1:0] REQ1_DVD, REQ1_DSR;
    logic          RSP_VALID, RSP_READY, RSP_ID;
    logic [RW-1:0] RSP_Q, RSP_R;
    logic [1:0]    RSP_ERR;
    logic          CORE_START, CORE_DONE;
    logic [DW-1:0] CORE_DVD, CORE_DSR;
    logic [RW-1:0] CORE_Q, CORE_R;

    div_share_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_DVD(REQ0_DVD), .REQ0_DSR(REQ0_DSR),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_DVD(REQ1_DVD), .REQ1_DSR(REQ1_DSR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_Q(RSP_Q), .RSP_R(RSP_R), .RSP_ERR(RSP_ERR),
        .CORE_START(CORE_START), .CORE_DVD(CORE_DVD), .CORE_DSR(CORE_DSR),
        .CORE_DONE(CORE_DONE), .CORE_Q(CORE_Q), .CORE_R(CORE_R)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // stimulus knobs, applied to the DUT once per cycle by step()
    bit            drv_rst, drv_v0, drv_v1, drv_rdy, drv_spur_done;
    logic [DW-1:0] drv_d0, drv_s0, drv_d1, drv_s1;
    int            force_delay = -1;

    // reference model: one transaction in flight, plus its expected timing
    int            cyc = 0;
    int            n_acc = 0;
    bit            busy, rr;
    bit            cur_id;
    logic [DW-1:0] cur_dvd, cur_dsr;
    logic [RW-1:0] exp_q, exp_r, core_q, core_r;
    logic [1:0]    exp_err;
    int            start_due = -1, done_cyc = -1, rsp_due = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return TIMEOUT - 1;
        if (r == 1) return TIMEOUT;
        if (r == 2) return TIMEOUT + 1;
        return int'($urandom_range(1, 8));
    endfunction

    task automatic model_accept(input bit id);
        logic [DW-1:0] q64, r64;
        int s, dly;
        n_acc++;
        busy    = 1'b1;
        rr      = !id;
        cur_id  = id;
        cur_dvd = id ? drv_d1 : drv_d0;
        cur_dsr = id ? drv_s1 : drv_s0;
        if (cur_dsr == 0) begin
            exp_q     = '1;
            exp_r     = cur_dvd[RW-1:0];
            exp_err   = 2'b01;
            rsp_due   = cyc + 1;
            start_due = -1;
            done_cyc  = -1;
        end else begin
            q64    = cur_dvd / cur_dsr;
            r64    = cur_dvd % cur_dsr;
            core_q = q64[RW-1:0];
            core_r = r64[RW-1:0];
            s      = cyc + 1;
            start_due = s;
            dly = (force_delay >= 0) ? force_delay : pick_delay();
            if (dly <= TIMEOUT) begin
                done_cyc = s + dly;
                rsp_due  = s + dly + 1;
                exp_q    = core_q;
                exp_r    = core_r;
                exp_err  = 2'b00;
            end else begin
                // watchdog answer; the core then pulses DONE late, during RESP
                rsp_due  = s + TIMEOUT + 1;
                done_cyc = rsp_due;
                exp_q    = '0;
                exp_r    = '0;
                exp_err  = 2'b10;
            end
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check READY,
    // then advance the model across the coming edge.
    task automatic step();
        bit e0, e1, hs;
        @(negedge CLK);
        if (!drv_rst) begin
            check_val("core_start", CORE_START, cyc == start_due);
            check_val("rsp_valid", RSP_VALID, busy && cyc >= rsp_due);
            if (busy && cyc >= rsp_due) begin
                check_val("rsp_id", RSP_ID, cur_id);
                check_val("rsp_q", RSP_Q, exp_q);
                check_val("rsp_r", RSP_R, exp_r);
                check_val("rsp_err", RSP_ERR, exp_err);
            end
            if (busy) begin
                check_val("core_dvd", CORE_DVD, cur_dvd);
                check_val("core_dsr", CORE_DSR, cur_dsr);
            end
        end
        RST        = drv_rst;
        REQ0_VALID = drv_v0;
        REQ0_DVD   = drv_d0;
        REQ0_DSR   = drv_s0;
        REQ1_VALID = drv_v1;
        REQ1_DVD   = drv_d1;
        REQ1_DSR   = drv_s1;
        RSP_READY  = drv_rdy;
        CORE_DONE  = (cyc == done_cyc) || drv_spur_done;
        if (cyc == done_cyc) begin
            CORE_Q = core_q;
            CORE_R = core_r;
        end else begin
            CORE_Q = RW'($urandom);
            CORE_R = RW'($urandom);
        end
        #1;
        if (drv_rst) begin
            busy      = 1'b0;
            rr        = 1'b0;
            start_due = -1;
            done_cyc  = -1;
            rsp_due   = 0;
        end else begin
            e0 = !busy && drv_v0 && (!drv_v1 || !rr);
            e1 = !busy && drv_v1 && (!drv_v0 || rr);
            check_val("req0_ready", REQ0_READY, e0);
            check_val("req1_ready", REQ1_READY, e1);
            hs = busy && cyc >= rsp_due && drv_rdy;
            if (e0 || e1) model_accept(e1);
            else if (hs) busy = 1'b0;
        end
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        drv_v0 = 0; drv_v1 = 0; drv_rdy = 1; drv_spur_done = 0;
        while (busy && n < 300) begin step(); n++; end
        check_val("drain_bound", busy, 0);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rsp_valid", RSP_VALID, 0);
        check_val("rst_rsp_id", RSP_ID, 0);
        check_val("rst_rsp_q", RSP_Q, 0);
        check_val("rst_rsp_r", RSP_R, 0);
        check_val("rst_rsp_err", RSP_ERR, 0);
        check_val("rst_core_start", CORE_START, 0);
        check_val("rst_core_dvd", CORE_DVD, 0);
        check_val("rst_core_dsr", CORE_DSR, 0);
    endtask

    // Single operation from one requester; optionally stall the response and
    // keep REQ0 pending during the stall.
    task automatic run_op(input bit id, input logic [DW-1:0] dvd, input logic [DW-1:0] dsr,
                          input int dly, input int stall, input bit pend0);
        int n = 0;
        int acc0 = n_acc;
        force_delay = dly;
        drv_rdy = 0;
        drv_v0 = !id; drv_v1 = id;
        if (id) begin drv_d1 = dvd; drv_s1 = dsr; end
        else    begin drv_d0 = dvd; drv_s0 = dsr; end
        while (n_acc == acc0 && n < 20) begin step(); n++; end
        check_val("accept_bound", n_acc != acc0, 1);
        drv_v1 = 0;
        drv_v0 = pend0;
        if (pend0) begin drv_d0 = 64'd1000; drv_s0 = 64'd9; end
        n = 0;
        while (busy && cyc <= rsp_due && n < 200) begin step(); n++; end
        repeat (stall) step();
        drv_rdy = 1;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        drain();
    endtask

    initial begin
        int rdy_cnt;
        int r;
        RST = 1; REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 0; CORE_DONE = 0;
        REQ0_DVD = '0; REQ0_DSR = '0; REQ1_DVD = '0; REQ1_DSR = '0;
        CORE_Q = '0; CORE_R = '0;
        drv_rst = 1; drv_v0 = 0; drv_v1 = 0; drv_rdy = 0; drv_spur_done = 0;
        drv_d0 = '0; drv_s0 = '0; drv_d1 = '0; drv_s1 = '0;
        repeat (2) step();
        drv_rst = 0;
        step();
        check_reset_outputs();

        // contention from reset: grants alternate 0,1,0,1 while both hold VALID
        force_delay = 6;
        drv_v0 = 1; drv_d0 = 64'd74;  drv_s0 = 64'd21;
        drv_v1 = 1; drv_d1 = 64'd100; drv_s1 = 64'd7;
        drv_rdy = 1;
        repeat (60) step();
        drain();

        run_op(1, 64'd55, 64'd0, 6, 0, 0);                   // divide by zero
        run_op(0, 64'd74, 64'd21, 1000, 0, 0);               // timeout + late DONE
        run_op(0, 64'd999, 64'd10, TIMEOUT, 2, 0);           // DONE on last WAIT cycle
        run_op(1, 64'd999, 64'd10, TIMEOUT - 1, 0, 0);
        run_op(0, 64'd74, 64'd21, 6, 10, 1);                 // backpressure, REQ0 pending

        // reset during WAIT, then a stale DONE
        run_op(1, 64'd7, 64'd3, 2, 0, 0);                    // leaves rr pointing at 0
        force_delay = 30;
        drv_v0 = 0; drv_v1 = 1; drv_d1 = 64'd500; drv_s1 = 64'd4;
        step();
        drv_v1 = 0;
        repeat (5) step();
        drv_rst = 1;
        step();
        drv_rst = 0;
        drv_spur_done = 1;
        step();
        drv_spur_done = 0;
        check_reset_outputs();
        repeat (4) step();
        check_val("post_rst_rsp_valid", RSP_VALID, 0);
        force_delay = 3;
        drv_v0 = 1; drv_d0 = 64'd81; drv_s0 = 64'd9;
        drv_v1 = 1; drv_d1 = 64'd82; drv_s1 = 64'd9;
        step();
        check_val("post_rst_grant0", REQ0_READY, 1);
        drain();

        // randomized traffic
        force_delay = -1;
        rdy_cnt = 0;
        drv_rdy = 1;
        repeat (4000) begin
            drv_v0 = ($urandom_range(0, 2) != 0);
            drv_v1 = ($urandom_range(0, 2) != 0);
            drv_d0 = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 300));
            drv_d1 = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 300));
            r = int'($urandom_range(0, 5));
            drv_s0 = (r == 0) ? '0 : (r < 3) ? DW'($urandom_range(1, 20)) : {$urandom, $urandom};
            r = int'($urandom_range(0, 5));
            drv_s1 = (r == 0) ? '0 : (r < 3) ? DW'($urandom_range(1, 20)) : {$urandom, $urandom};
            if (rdy_cnt == 0) begin
                drv_rdy = !drv_rdy;
                rdy_cnt = drv_rdy ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 12));
            end else begin
                rdy_cnt--;
            end
            drv_spur_done = !busy && ($urandom_range(0, 7) == 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
